// File: rtl/ls_buffer.sv
// -----------------------------------------------------------------------------
// ls_buffer
//
// Load/store buffer for the out-of-order core. Memory ops arrive from the
// decoder, wait in a circular queue for their base/store-data operands
// (captured from the ALU CDB and from this block's own load CDB), and issue
// strictly in program order, one at a time, to the memory controller. Loads
// broadcast their extended result on ls_cdb. Stores issue only after the ROB
// commits their tag. A flush keeps the committed stores at the head and
// drops everything behind them.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   ena                         global stall when low (handshake still sampled)
//   in_flush                    misbranch flush
//   in_alloc_*                  decoder allocation (op, tag, imm, operands)
//   out_full                    registered: no allocation next cycle
//   in_cdb_rob_tag/value        ALU CDB broadcast
//   in_committed_rob_tag        store commit from the ROB (0 = none)
//   out_mem_*                   registered memory request
//   in_mem_done/rdata           completion pulse and raw read data
//   out_ls_cdb_rob_tag/value    registered load result pulse (tag 0 = idle)
//
// Configuration macro:
//   LSB_DEBUG_EN  when defined, adds registered debug_count (occupancy) and
//                 debug_head_tag (head rob_tag, 0 when empty) outputs.
// -----------------------------------------------------------------------------
module ls_buffer #(
  parameter int DEPTH = 8,
  parameter int ROB_W = 4,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_flush,
  input  logic             in_alloc_ena,
  input  logic             in_alloc_is_store,
  input  logic [2:0]       in_alloc_funct3,
  input  logic [ROB_W-1:0] in_alloc_rob_tag,
  input  logic [XLEN-1:0]  in_alloc_imm,
  input  logic [ROB_W-1:0] in_alloc_q1,
  input  logic [XLEN-1:0]  in_alloc_v1,
  input  logic [ROB_W-1:0] in_alloc_q2,
  input  logic [XLEN-1:0]  in_alloc_v2,
  output logic             out_full,
  input  logic [ROB_W-1:0] in_cdb_rob_tag,
  input  logic [XLEN-1:0]  in_cdb_value,
  input  logic [ROB_W-1:0] in_committed_rob_tag,
  output logic             out_mem_req,
  output logic             out_mem_we,
  output logic [XLEN-1:0]  out_mem_addr,
  output logic [XLEN-1:0]  out_mem_wdata,
  output logic [1:0]       out_mem_size,
  input  logic             in_mem_done,
  input  logic [XLEN-1:0]  in_mem_rdata,
  output logic [ROB_W-1:0] out_ls_cdb_rob_tag,
  output logic [XLEN-1:0]  out_ls_cdb_value
`ifdef LSB_DEBUG_EN
  ,
  output logic [$clog2(DEPTH):0] debug_count,
  output logic [ROB_W-1:0]       debug_head_tag
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [ROB_W-1:0] TAG_NONE   = {ROB_W{1'b0}};
  localparam logic [XLEN-1:0]  XLEN_ZERO  = {XLEN{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ALMOST = CNT_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ZERO   = {PTR_W{1'b0}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // A waiting operand tag matches a broadcast; tag 0 never matches.
  function automatic logic tag_hit(input logic [ROB_W-1:0] q, input logic [ROB_W-1:0] t);
    return (q != TAG_NONE) && (q == t);
  endfunction

  // Sign/zero-extend raw read data by RV32 load funct3.
  function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3, input logic [XLEN-1:0] raw);
    case (f3)
      3'b000:  return {{(XLEN-8){raw[7]}}, raw[7:0]};
      3'b001:  return {{(XLEN-16){raw[15]}}, raw[15:0]};
      3'b100:  return {{(XLEN-8){1'b0}}, raw[7:0]};
      3'b101:  return {{(XLEN-16){1'b0}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  // Keep only the bytes the store writes, LSB-aligned.
  function automatic logic [XLEN-1:0] store_align(input logic [1:0] sz, input logic [XLEN-1:0] v);
    case (sz)
      2'b00:   return {{(XLEN-8){1'b0}}, v[7:0]};
      2'b01:   return {{(XLEN-16){1'b0}}, v[15:0]};
      default: return v;
    endcase
  endfunction

  // Entry storage
  logic             busy_r      [DEPTH];
  logic             is_store_r  [DEPTH];
  logic [2:0]       funct3_r    [DEPTH];
  logic [ROB_W-1:0] rob_tag_r   [DEPTH];
  logic [XLEN-1:0]  imm_r       [DEPTH];
  logic [ROB_W-1:0] q1_r        [DEPTH];
  logic [XLEN-1:0]  v1_r        [DEPTH];
  logic [ROB_W-1:0] q2_r        [DEPTH];
  logic [XLEN-1:0]  v2_r        [DEPTH];
  logic             committed_r [DEPTH];

  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;

  state_e           fsm_r;
  logic             squash_r;          // in-flight load was flushed
  logic             done_pend_r;       // completion seen while stalled
  logic [XLEN-1:0]  rdata_pend_r;
  logic             inflight_is_store_r;
  logic [2:0]       inflight_funct3_r;
  logic [ROB_W-1:0] inflight_tag_r;

  logic [DEPTH-1:0] commit_hit_s;
  logic [DEPTH-1:0] keep_s;
  logic [CNT_W-1:0] kept_cnt_s;
  logic             alloc_s;
  logic             done_s;
  logic [XLEN-1:0]  rdata_s;
  logic             pop_s;
  logic             pop_keep_s;
  logic             head_ready_s;
  logic             issue_s;
  logic [PTR_W-1:0] head_next_s;
  logic [PTR_W-1:0] tail_next_s;
  logic [CNT_W-1:0] count_next_s;
  logic             full_next_s;

  // Per-entry store commit match for this cycle
  always_comb begin
    commit_hit_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (busy_r[i] && is_store_r[i] && tag_hit(rob_tag_r[i], in_committed_rob_tag)) begin
        commit_hit_s[i] = 1'b1;
      end else begin
        commit_hit_s[i] = 1'b0;
      end
    end
  end

  // Run of committed stores starting at the head survives a flush
  always_comb begin
    logic             run_v;
    logic [PTR_W-1:0] idx_v;
    keep_s     = {DEPTH{1'b0}};
    kept_cnt_s = CNT_ZERO;
    run_v      = 1'b1;
    idx_v      = PTR_ZERO;
    for (int i = 0; i < DEPTH; i++) begin
      idx_v = head_r + PTR_W'(i);
      if (run_v && (CNT_W'(i) < count_r) && is_store_r[idx_v] &&
          (committed_r[idx_v] || commit_hit_s[idx_v])) begin
        keep_s[idx_v] = 1'b1;
        kept_cnt_s    = kept_cnt_s + CNT_W'(1'b1);
      end else begin
        run_v = 1'b0;
      end
    end
  end

  // Handshake, issue and queue pointer next-state
  always_comb begin
    alloc_s = in_alloc_ena && !in_flush && (count_r != CNT_FULL);
    done_s  = (fsm_r == ST_WAIT) && (in_mem_done || done_pend_r);
    rdata_s = in_mem_done ? in_mem_rdata : rdata_pend_r;
    // A squashed load's entry is already gone, so its completion pops nothing.
    pop_s   = done_s && !squash_r;
    // Under flush only an in-flight store's entry is still in the queue.
    pop_keep_s = pop_s && inflight_is_store_r;

    head_ready_s = (count_r != CNT_ZERO) && busy_r[head_r] && (q1_r[head_r] == TAG_NONE) &&
                   (!is_store_r[head_r] || ((q2_r[head_r] == TAG_NONE) && committed_r[head_r]));
    issue_s = (fsm_r == ST_IDLE) && !in_flush && head_ready_s;

    if (in_flush) begin
      head_next_s  = head_r + PTR_W'(pop_keep_s);
      tail_next_s  = head_r + kept_cnt_s[PTR_W-1:0];
      count_next_s = kept_cnt_s - CNT_W'(pop_keep_s);
    end else begin
      head_next_s  = head_r + PTR_W'(pop_s);
      tail_next_s  = tail_r + PTR_W'(alloc_s);
      count_next_s = count_r + CNT_W'(alloc_s) - CNT_W'(pop_s);
    end
    full_next_s = (count_next_s >= CNT_ALMOST);
  end

  // Queue, entry fields, issue FSM and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r              <= PTR_ZERO;
      tail_r              <= PTR_ZERO;
      count_r             <= CNT_ZERO;
      fsm_r               <= ST_IDLE;
      squash_r            <= 1'b0;
      done_pend_r         <= 1'b0;
      rdata_pend_r        <= XLEN_ZERO;
      inflight_is_store_r <= 1'b0;
      inflight_funct3_r   <= 3'b000;
      inflight_tag_r      <= TAG_NONE;
      out_full            <= 1'b0;
      out_mem_req         <= 1'b0;
      out_mem_we          <= 1'b0;
      out_mem_addr        <= XLEN_ZERO;
      out_mem_wdata       <= XLEN_ZERO;
      out_mem_size        <= 2'b00;
      out_ls_cdb_rob_tag  <= TAG_NONE;
      out_ls_cdb_value    <= XLEN_ZERO;
      for (int j = 0; j < DEPTH; j++) begin
        busy_r[j]      <= 1'b0;
        is_store_r[j]  <= 1'b0;
        funct3_r[j]    <= 3'b000;
        rob_tag_r[j]   <= TAG_NONE;
        imm_r[j]       <= XLEN_ZERO;
        q1_r[j]        <= TAG_NONE;
        v1_r[j]        <= XLEN_ZERO;
        q2_r[j]        <= TAG_NONE;
        v2_r[j]        <= XLEN_ZERO;
        committed_r[j] <= 1'b0;
      end
    end else begin
      // The load result is a single-cycle pulse even while stalled.
      out_ls_cdb_rob_tag <= TAG_NONE;
      out_ls_cdb_value   <= XLEN_ZERO;

      if (ena) begin
        head_r   <= head_next_s;
        tail_r   <= tail_next_s;
        count_r  <= count_next_s;
        out_full <= full_next_s;

        for (int j = 0; j < DEPTH; j++) begin
          if (busy_r[j] && tag_hit(q1_r[j], in_cdb_rob_tag)) begin
            q1_r[j] <= TAG_NONE;
            v1_r[j] <= in_cdb_value;
          end else if (busy_r[j] && tag_hit(q1_r[j], out_ls_cdb_rob_tag)) begin
            q1_r[j] <= TAG_NONE;
            v1_r[j] <= out_ls_cdb_value;
          end
          if (busy_r[j] && tag_hit(q2_r[j], in_cdb_rob_tag)) begin
            q2_r[j] <= TAG_NONE;
            v2_r[j] <= in_cdb_value;
          end else if (busy_r[j] && tag_hit(q2_r[j], out_ls_cdb_rob_tag)) begin
            q2_r[j] <= TAG_NONE;
            v2_r[j] <= out_ls_cdb_value;
          end
          if (commit_hit_s[j]) begin
            committed_r[j] <= 1'b1;
          end
          if (in_flush) begin
            busy_r[j] <= keep_s[j] && !(pop_keep_s && (head_r == PTR_W'(j)));
          end else if (pop_s && (head_r == PTR_W'(j))) begin
            busy_r[j] <= 1'b0;
          end
        end

        // Allocation captures a coincident broadcast so it is never missed.
        if (alloc_s) begin
          busy_r[tail_r]      <= 1'b1;
          is_store_r[tail_r]  <= in_alloc_is_store;
          funct3_r[tail_r]    <= in_alloc_funct3;
          rob_tag_r[tail_r]   <= in_alloc_rob_tag;
          imm_r[tail_r]       <= in_alloc_imm;
          committed_r[tail_r] <= 1'b0;
          if (tag_hit(in_alloc_q1, in_cdb_rob_tag)) begin
            q1_r[tail_r] <= TAG_NONE;
            v1_r[tail_r] <= in_cdb_value;
          end else if (tag_hit(in_alloc_q1, out_ls_cdb_rob_tag)) begin
            q1_r[tail_r] <= TAG_NONE;
            v1_r[tail_r] <= out_ls_cdb_value;
          end else begin
            q1_r[tail_r] <= in_alloc_q1;
            v1_r[tail_r] <= in_alloc_v1;
          end
          if (tag_hit(in_alloc_q2, in_cdb_rob_tag)) begin
            q2_r[tail_r] <= TAG_NONE;
            v2_r[tail_r] <= in_cdb_value;
          end else if (tag_hit(in_alloc_q2, out_ls_cdb_rob_tag)) begin
            q2_r[tail_r] <= TAG_NONE;
            v2_r[tail_r] <= out_ls_cdb_value;
          end else begin
            q2_r[tail_r] <= in_alloc_q2;
            v2_r[tail_r] <= in_alloc_v2;
          end
        end

        case (fsm_r)
          ST_IDLE: begin
            if (issue_s) begin
              out_mem_req         <= 1'b1;
              out_mem_we          <= is_store_r[head_r];
              out_mem_addr        <= v1_r[head_r] + imm_r[head_r];
              out_mem_wdata       <= store_align(funct3_r[head_r][1:0], v2_r[head_r]);
              out_mem_size        <= funct3_r[head_r][1:0];
              inflight_is_store_r <= is_store_r[head_r];
              inflight_funct3_r   <= funct3_r[head_r];
              inflight_tag_r      <= rob_tag_r[head_r];
              squash_r            <= 1'b0;
              fsm_r               <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (done_s) begin
              out_mem_req <= 1'b0;
              out_mem_we  <= 1'b0;
              done_pend_r <= 1'b0;
              squash_r    <= 1'b0;
              fsm_r       <= ST_IDLE;
              if (!inflight_is_store_r && !squash_r && !in_flush) begin
                out_ls_cdb_rob_tag <= inflight_tag_r;
                out_ls_cdb_value   <= load_extend(inflight_funct3_r, rdata_s);
              end
            end else if (in_flush && !inflight_is_store_r) begin
              squash_r <= 1'b1;
            end
          end
          default: begin
            out_mem_req <= 1'b0;
            fsm_r       <= ST_IDLE;
          end
        endcase
      end else begin
        // Stalled: remember a completion so the handshake is not lost.
        if ((fsm_r == ST_WAIT) && in_mem_done) begin
          done_pend_r  <= 1'b1;
          rdata_pend_r <= in_mem_rdata;
        end
      end
    end
  end

`ifdef LSB_DEBUG_EN
  logic [ROB_W-1:0] head_tag_next_s;

  // Head tag after this cycle, including an allocation into an empty queue
  always_comb begin
    if (count_next_s == CNT_ZERO) begin
      head_tag_next_s = TAG_NONE;
    end else if (alloc_s && (tail_r == head_next_s)) begin
      head_tag_next_s = in_alloc_rob_tag;
    end else begin
      head_tag_next_s = rob_tag_r[head_next_s];
    end
  end

  // Registered debug observation of occupancy and head tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      debug_count    <= CNT_ZERO;
      debug_head_tag <= TAG_NONE;
    end else if (ena) begin
      debug_count    <= count_next_s;
      debug_head_tag <= head_tag_next_s;
    end
  end
`endif

endmodule

// File: tb/tb_ls_buffer.sv
// -----------------------------------------------------------------------------
// tb_ls_buffer: directed self-checking bench for ls_buffer (DEPTH=8, ROB_W=4,
// XLEN=32). Inputs change 1 time unit after the rising edge; outputs are
// sampled at that same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_ls_buffer;

  localparam int DEPTH = 8;
  localparam int ROB_W = 4;
  localparam int XLEN  = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ena;
  logic             in_flush;
  logic             in_alloc_ena;
  logic             in_alloc_is_store;
  logic [2:0]       in_alloc_funct3;
  logic [ROB_W-1:0] in_alloc_rob_tag;
  logic [XLEN-1:0]  in_alloc_imm;
  logic [ROB_W-1:0] in_alloc_q1;
  logic [XLEN-1:0]  in_alloc_v1;
  logic [ROB_W-1:0] in_alloc_q2;
  logic [XLEN-1:0]  in_alloc_v2;
  logic             out_full;
  logic [ROB_W-1:0] in_cdb_rob_tag;
  logic [XLEN-1:0]  in_cdb_value;
  logic [ROB_W-1:0] in_committed_rob_tag;
  logic             out_mem_req;
  logic             out_mem_we;
  logic [XLEN-1:0]  out_mem_addr;
  logic [XLEN-1:0]  out_mem_wdata;
  logic [1:0]       out_mem_size;
  logic             in_mem_done;
  logic [XLEN-1:0]  in_mem_rdata;
  logic [ROB_W-1:0] out_ls_cdb_rob_tag;
  logic [XLEN-1:0]  out_ls_cdb_value;
`ifdef LSB_DEBUG_EN
  logic [$clog2(DEPTH):0] debug_count;
  logic [ROB_W-1:0]       debug_head_tag;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ls_buffer #(.DEPTH(DEPTH), .ROB_W(ROB_W), .XLEN(XLEN)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .ena                  (ena),
    .in_flush             (in_flush),
    .in_alloc_ena         (in_alloc_ena),
    .in_alloc_is_store    (in_alloc_is_store),
    .in_alloc_funct3      (in_alloc_funct3),
    .in_alloc_rob_tag     (in_alloc_rob_tag),
    .in_alloc_imm         (in_alloc_imm),
    .in_alloc_q1          (in_alloc_q1),
    .in_alloc_v1          (in_alloc_v1),
    .in_alloc_q2          (in_alloc_q2),
    .in_alloc_v2          (in_alloc_v2),
    .out_full             (out_full),
    .in_cdb_rob_tag       (in_cdb_rob_tag),
    .in_cdb_value         (in_cdb_value),
    .in_committed_rob_tag (in_committed_rob_tag),
    .out_mem_req          (out_mem_req),
    .out_mem_we           (out_mem_we),
    .out_mem_addr         (out_mem_addr),
    .out_mem_wdata        (out_mem_wdata),
    .out_mem_size         (out_mem_size),
    .in_mem_done          (in_mem_done),
    .in_mem_rdata         (in_mem_rdata),
    .out_ls_cdb_rob_tag   (out_ls_cdb_rob_tag),
    .out_ls_cdb_value     (out_ls_cdb_value)
`ifdef LSB_DEBUG_EN
    ,
    .debug_count          (debug_count),
    .debug_head_tag       (debug_head_tag)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic alloc_op(input logic st, input logic [2:0] f3, input logic [3:0] tag,
                          input logic [31:0] imm, input logic [3:0] q1, input logic [31:0] v1,
                          input logic [3:0] q2, input logic [31:0] v2);
    in_alloc_ena      = 1'b1;
    in_alloc_is_store = st;
    in_alloc_funct3   = f3;
    in_alloc_rob_tag  = tag;
    in_alloc_imm      = imm;
    in_alloc_q1       = q1;
    in_alloc_v1       = v1;
    in_alloc_q2       = q2;
    in_alloc_v2       = v2;
    step();
    in_alloc_ena      = 1'b0;
  endtask

  // Wait (bounded) for a load request, complete it, and check the broadcast.
  task automatic serve_load(input string tag, input logic [31:0] exp_addr, input logic [31:0] rdata,
                            input logic [3:0] exp_tag, input logic [31:0] exp_val);
    int n = 0;
    while (!out_mem_req && n < 30) begin
      step();
      n++;
    end
    check({tag, "_req"}, {31'd0, out_mem_req}, 32'd1);
    check({tag, "_we"}, {31'd0, out_mem_we}, 32'd0);
    check({tag, "_addr"}, out_mem_addr, exp_addr);
    in_mem_done  = 1'b1;
    in_mem_rdata = rdata;
    step();
    in_mem_done  = 1'b0;
    check({tag, "_cdb_tag"}, {28'd0, out_ls_cdb_rob_tag}, {28'd0, exp_tag});
    check({tag, "_cdb_val"}, out_ls_cdb_value, exp_val);
  endtask

  initial begin
    rst_n                = 1'b0;
    ena                  = 1'b1;
    in_flush             = 1'b0;
    in_alloc_ena         = 1'b0;
    in_alloc_is_store    = 1'b0;
    in_alloc_funct3      = 3'b000;
    in_alloc_rob_tag     = 4'd0;
    in_alloc_imm         = 32'd0;
    in_alloc_q1          = 4'd0;
    in_alloc_v1          = 32'd0;
    in_alloc_q2          = 4'd0;
    in_alloc_v2          = 32'd0;
    in_cdb_rob_tag       = 4'd0;
    in_cdb_value         = 32'd0;
    in_committed_rob_tag = 4'd0;
    in_mem_done          = 1'b0;
    in_mem_rdata         = 32'd0;

    // Reset values
    step();
    step();
    check("rst_full", {31'd0, out_full}, 32'd0);
    check("rst_req", {31'd0, out_mem_req}, 32'd0);
    check("rst_we", {31'd0, out_mem_we}, 32'd0);
    check("rst_addr", out_mem_addr, 32'd0);
    check("rst_wdata", out_mem_wdata, 32'd0);
    check("rst_size", {30'd0, out_mem_size}, 32'd0);
    check("rst_cdb_tag", {28'd0, out_ls_cdb_rob_tag}, 32'd0);
    check("rst_cdb_val", out_ls_cdb_value, 32'd0);
    rst_n = 1'b1;
    step();

    // LW with ready base: 0x100 + 4
    alloc_op(1'b0, 3'b010, 4'd1, 32'd4, 4'd0, 32'h100, 4'd0, 32'd0);
    check("lw_not_same_cycle", {31'd0, out_mem_req}, 32'd0);
    step();
    check("lw_size", {30'd0, out_mem_size}, 32'd2);
    serve_load("lw", 32'h104, 32'hDEADBEEF, 4'd1, 32'hDEADBEEF);
    step();
    check("lw_pulse_end", {28'd0, out_ls_cdb_rob_tag}, 32'd0);
    check("lw_empty_req", {31'd0, out_mem_req}, 32'd0);

    // LB whose base arrives on the CDB in the allocation cycle
    in_cdb_rob_tag = 4'd3;
    in_cdb_value   = 32'h200;
    alloc_op(1'b0, 3'b000, 4'd2, 32'd0, 4'd3, 32'd0, 4'd0, 32'd0);
    in_cdb_rob_tag = 4'd0;
    in_cdb_value   = 32'd0;
    serve_load("lb", 32'h200, 32'h00000080, 4'd2, 32'hFFFFFF80);
    step();

    // Same with LBU
    in_cdb_rob_tag = 4'd3;
    in_cdb_value   = 32'h200;
    alloc_op(1'b0, 3'b100, 4'd4, 32'd0, 4'd3, 32'd0, 4'd0, 32'd0);
    in_cdb_rob_tag = 4'd0;
    in_cdb_value   = 32'd0;
    serve_load("lbu", 32'h200, 32'h00000080, 4'd4, 32'h00000080);
    step();

    // SW ready but uncommitted must wait
    alloc_op(1'b1, 3'b010, 4'd5, 32'd8, 4'd0, 32'h300, 4'd0, 32'h12345678);
    for (int i = 0; i < 10; i++) begin
      step();
      check("sw_uncommitted_req", {31'd0, out_mem_req}, 32'd0);
    end
    in_committed_rob_tag = 4'd5;
    step();
    in_committed_rob_tag = 4'd0;
    step();
    check("sw_req", {31'd0, out_mem_req}, 32'd1);
    check("sw_we", {31'd0, out_mem_we}, 32'd1);
    check("sw_addr", out_mem_addr, 32'h308);
    check("sw_wdata", out_mem_wdata, 32'h12345678);
    check("sw_size", {30'd0, out_mem_size}, 32'd2);
    in_mem_done = 1'b1;
    step();
    in_mem_done = 1'b0;
    check("sw_done_req", {31'd0, out_mem_req}, 32'd0);
    check("sw_no_cdb", {28'd0, out_ls_cdb_rob_tag}, 32'd0);
    step();

    // Fill: eight loads waiting on tag 7, imm = 4*i
    for (int i = 0; i < DEPTH; i++) begin
      alloc_op(1'b0, 3'b010, 4'(8 + i), 32'(4 * i), 4'd7, 32'd0, 4'd0, 32'd0);
      check("fill_full", {31'd0, out_full}, (i >= DEPTH - 2) ? 32'd1 : 32'd0);
    end
    // Ignored: queue already holds DEPTH entries
    alloc_op(1'b0, 3'b010, 4'd5, 32'd0, 4'd0, 32'hBAD, 4'd0, 32'd0);
    check("overfill_full", {31'd0, out_full}, 32'd1);
    check("overfill_no_req", {31'd0, out_mem_req}, 32'd0);
    in_cdb_rob_tag = 4'd7;
    in_cdb_value   = 32'h400;
    step();
    in_cdb_rob_tag = 4'd0;
    in_cdb_value   = 32'd0;
    serve_load("fill0", 32'h400, 32'h11, 4'd8, 32'h11);
    // One pop frees a slot
    alloc_op(1'b0, 3'b010, 4'd6, 32'd0, 4'd0, 32'h900, 4'd0, 32'd0);
    for (int i = 1; i < DEPTH; i++) begin
      serve_load("fill", 32'h400 + 32'(4 * i), 32'(i), 4'(8 + i), 32'(i));
    end
    serve_load("after_pop", 32'h900, 32'h77, 4'd6, 32'h77);
    step();
    check("drained_full", {31'd0, out_full}, 32'd0);
    check("drained_req", {31'd0, out_mem_req}, 32'd0);

    // Committed SW at head, uncommitted LW and SW behind it, then flush
    alloc_op(1'b1, 3'b010, 4'd1, 32'd0, 4'd0, 32'h500, 4'd0, 32'hCAFE0001);
    in_committed_rob_tag = 4'd1;
    alloc_op(1'b0, 3'b010, 4'd2, 32'd0, 4'd0, 32'h600, 4'd0, 32'd0);
    in_committed_rob_tag = 4'd0;
    alloc_op(1'b1, 3'b010, 4'd3, 32'd0, 4'd0, 32'h680, 4'd0, 32'hBEEF);
    check("fl_sw_req", {31'd0, out_mem_req}, 32'd1);
    check("fl_sw_we", {31'd0, out_mem_we}, 32'd1);
    check("fl_sw_addr", out_mem_addr, 32'h500);
    check("fl_sw_wdata", out_mem_wdata, 32'hCAFE0001);
    in_flush = 1'b1;
    step();
    in_flush = 1'b0;
    check("fl_sw_held", {31'd0, out_mem_req}, 32'd1);
    in_mem_done = 1'b1;
    step();
    in_mem_done = 1'b0;
    check("fl_sw_done", {31'd0, out_mem_req}, 32'd0);
    check("fl_sw_no_cdb", {28'd0, out_ls_cdb_rob_tag}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("fl_dropped_no_req", {31'd0, out_mem_req}, 32'd0);
    end
    check("fl_full", {31'd0, out_full}, 32'd0);

    // Load in flight when the flush hits
    alloc_op(1'b0, 3'b010, 4'd9, 32'h10, 4'd0, 32'h700, 4'd0, 32'd0);
    step();
    check("fl_ld_req", {31'd0, out_mem_req}, 32'd1);
    check("fl_ld_addr", out_mem_addr, 32'h710);
    in_flush = 1'b1;
    step();
    in_flush = 1'b0;
    check("fl_ld_held", {31'd0, out_mem_req}, 32'd1);
    in_mem_done  = 1'b1;
    in_mem_rdata = 32'h55;
    step();
    in_mem_done  = 1'b0;
    check("fl_ld_done_req", {31'd0, out_mem_req}, 32'd0);
    check("fl_ld_no_cdb", {28'd0, out_ls_cdb_rob_tag}, 32'd0);
    step();
    check("fl_ld_idle", {31'd0, out_mem_req}, 32'd0);

    // Negative offset, completion arriving during a stall
    alloc_op(1'b0, 3'b010, 4'd10, 32'hFFFFFFFC, 4'd0, 32'h800, 4'd0, 32'd0);
    step();
    check("st_req", {31'd0, out_mem_req}, 32'd1);
    check("st_addr", out_mem_addr, 32'h7FC);
    ena          = 1'b0;
    in_mem_done  = 1'b1;
    in_mem_rdata = 32'hA5A5A5A5;
    step();
    in_mem_done  = 1'b0;
    check("st_hold_req", {31'd0, out_mem_req}, 32'd1);
    check("st_hold_cdb", {28'd0, out_ls_cdb_rob_tag}, 32'd0);
    step();
    check("st_hold_req2", {31'd0, out_mem_req}, 32'd1);
    ena = 1'b1;
    step();
    check("st_cdb_tag", {28'd0, out_ls_cdb_rob_tag}, 32'd10);
    check("st_cdb_val", out_ls_cdb_value, 32'hA5A5A5A5);
    check("st_req_low", {31'd0, out_mem_req}, 32'd0);
    step();
    check("st_pulse_end", {28'd0, out_ls_cdb_rob_tag}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ls_buffer.md
# ls_buffer

Load/store buffer for the out-of-order core. It accepts memory ops from the decoder and captures address-base and store-data operands from the CDB. Ops are issued strictly in program order to the memory controller, one at a time. Load results are broadcast on the load/store CDB (`ls_cdb`) that the ROB consumes; a store reaches memory only after the ROB commits its tag. On misbranch, all uncommitted entries are squashed.

## Interface
Parameters:
- DEPTH, 8, number of entries; power of two
- ROB_W, 4, ROB tag width; tag 0 means "no tag / value ready"
- XLEN, 32, data and address width

Ports:
- clk, in, 1, clock
- rst_n, in, 1, asynchronous active-low reset
- ena, in, 1, global stall when low; all state holds, memory handshake inputs are still sampled
- in_flush, in, 1, misbranch flush from the ROB
- in_alloc_ena, in, 1, decoder allocates one entry
- in_alloc_is_store, in, 1, 1 = store, 0 = load
- in_alloc_funct3, in, 3, RV32 width/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
- in_alloc_rob_tag, in, ROB_W, destination ROB tag of the op
- in_alloc_imm, in, XLEN, sign-extended offset
- in_alloc_q1 / in_alloc_v1, in, ROB_W / XLEN, base tag / base value
- in_alloc_q2 / in_alloc_v2, in, ROB_W / XLEN, store-data tag / value; ignored for loads
- out_full, out, 1, no allocation allowed next cycle
- in_cdb_rob_tag / in_cdb_value, in, ROB_W / XLEN, ALU CDB broadcast
- in_committed_rob_tag, in, ROB_W, store committed by the ROB; 0 = none
- out_mem_req, out, 1, memory request valid
- out_mem_we, out, 1, 1 = write
- out_mem_addr, out, XLEN, byte address
- out_mem_wdata, out, XLEN, store data, LSB-aligned
- out_mem_size, out, 2, 0 = byte, 1 = half, 2 = word
- in_mem_done, in, 1, one-cycle completion pulse
- in_mem_rdata, in, XLEN, raw read data; valid with in_mem_done
- out_ls_cdb_rob_tag / out_ls_cdb_value, out, ROB_W / XLEN, load result broadcast; tag 0 = idle

## Operation
- Circular queue with head, tail and count; pointers wrap modulo DEPTH.
- Per-entry state: busy, is_store, funct3, rob_tag, imm, q1/v1, q2/v2, committed.
- **Operand capture.** Every cycle, each busy entry with q == in_cdb_rob_tag (nonzero) or q == out_ls_cdb_rob_tag (nonzero) takes the value and clears q to 0. The same compare is applied to alloc operands in the allocation cycle, so a broadcast coincident with allocation is never lost.
- **Commit.** A store entry with rob_tag == in_committed_rob_tag sets committed.
- **Eligibility.** Only the head entry can be issued.
  - Load: q1 == 0.
  - Store: q1 == 0, q2 == 0 and committed.
- **Address.** v1 + imm, modulo 2^XLEN. Size comes from funct3[1:0].
- **FSM IDLE.** If the head is eligible, drive the request and go to WAIT.
- **FSM WAIT.** Hold the request until in_mem_done. Then:
  - Load: broadcast the result, sign- or zero-extended per funct3 from in_mem_rdata[7:0] or [15:0].
  - Pop the head and return to IDLE.
- **Flush.** Committed stores are contiguous from the head and are kept. All later entries are dropped, and tail is set to just after the last committed store (tail = head if there is none).
  - An in-flight load still completes its handshake, but its broadcast is suppressed.
  - An in-flight store is committed, so it completes normally.
  - Allocation in a flush cycle is ignored.
- **Allocation when full.** Allocation while count == DEPTH is a protocol error: it is ignored and the queue is unchanged.

## Timing
- Reset values: out_full = 0, out_mem_req = 0, out_mem_we = 0, out_mem_addr = 0, out_mem_wdata = 0, out_mem_size = 0, out_ls_cdb_rob_tag = 0, out_ls_cdb_value = 0. Queue empty, FSM in IDLE, all busy bits clear.
- Allocation is registered; an entry can issue no earlier than the cycle after it is allocated.
- Head eligible in cycle N → out_mem_req = 1 in cycle N+1.
- in_mem_done in cycle M → out_mem_req = 0 and, for a load, a one-cycle out_ls_cdb pulse in cycle M+1. The next issue is no earlier than M+2.
- out_full is registered: it is set when count ≥ DEPTH−1 after the current cycle's allocations and pops.
- Simultaneous alloc, pop and commit in one cycle: count = count + alloc − pop.
- With ena low, the FSM, queue and outputs hold, except that the out_ls_cdb pulse still clears to 0 after one cycle.

## Configuration
- LSB_DEBUG_EN
  - Defined: adds output ports debug_count (log2(DEPTH)+1 bits, current occupancy) and debug_head_tag (ROB_W bits, head rob_tag, 0 when empty), both registered and 0 at reset.
  - Undefined: the ports and their logic are absent; functional behaviour is identical.

## Test plan
- Reset, then LW with base ready (v1 = 0x100, imm = 4); mem_done with rdata 0xDEADBEEF → addr 0x104, size 2, cdb pulse value 0xDEADBEEF with the correct tag.
- LB with base tag 3; CDB broadcasts tag 3 = 0x200 in the alloc cycle; rdata 0x80 → addr 0x200, value 0xFFFFFF80. The same with LBU → 0x00000080.
- SW ready but uncommitted for 10 cycles → no out_mem_req. Commit its tag → req with we = 1 the next cycle, data LSB-aligned, no cdb pulse.
- Fill DEPTH entries → out_full = 1 when DEPTH−1 entries are held. A further alloc is ignored; after one pop, allocation works.
- Committed SW at head, uncommitted LW and SW behind it, flush → only the committed store remains and issues, queue ends empty.
- Load in flight, flush, then mem_done → no cdb pulse, queue empty, FSM back in IDLE.
